// File: rtl/tt_bist_harness_if.sv
// Handshake/bus bundle between the BIST harness and its controller/DUT side.
// With BIST_SEED_LOAD_EN defined the bundle also carries a run-time seed.
interface tt_bist_harness_if #(
  parameter int unsigned WIDTH = 8
);
  logic             ena;
  logic             start_i;
  logic [WIDTH-1:0] stim_o;
  logic             stim_valid_o;
  logic [WIDTH-1:0] resp_i;
  logic             busy_o;
  logic             done_o;
  logic             pass_o;
  logic [WIDTH-1:0] signature_o;
`ifdef BIST_SEED_LOAD_EN
  logic [WIDTH-1:0] seed_i;

  modport master (
    input  ena, start_i, resp_i, seed_i,
    output stim_o, stim_valid_o, busy_o, done_o, pass_o, signature_o
  );
  modport slave (
    output ena, start_i, resp_i, seed_i,
    input  stim_o, stim_valid_o, busy_o, done_o, pass_o, signature_o
  );
`else
  modport master (
    input  ena, start_i, resp_i,
    output stim_o, stim_valid_o, busy_o, done_o, pass_o, signature_o
  );
  modport slave (
    output ena, start_i, resp_i,
    input  stim_o, stim_valid_o, busy_o, done_o, pass_o, signature_o
  );
`endif
endinterface

// File: rtl/tt_bist_harness.sv
// Self-test harness: Galois LFSR stimulus, MISR response compaction, golden compare.
// Optional BIST_SEED_LOAD_EN: LFSR is loaded from seed_i (zero falls back to SEED).
module tt_bist_harness #(
  parameter int unsigned      WIDTH        = 8,
  parameter int unsigned      NUM_PATTERNS = 256,
  parameter int unsigned      LATENCY      = 0,
  parameter logic [WIDTH-1:0] LFSR_POLY    = WIDTH'(8'hB8),
  parameter logic [WIDTH-1:0] SEED         = WIDTH'(8'h01),
  parameter logic [WIDTH-1:0] GOLDEN       = WIDTH'(8'h00)
) (
  input  logic               clk,
  input  logic               rst_n,
  tt_bist_harness_if.master  bus
);

  localparam int unsigned PIPE_W = (LATENCY == 0) ? 1 : LATENCY;
  localparam logic [15:0] LAST_PAT   = 16'(NUM_PATTERNS - 1);
  localparam logic [2:0]  LAST_DRAIN = 3'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_r, state_next_s;
  logic [WIDTH-1:0]    lfsr_r, misr_r, misr_next_s, stim_r, seed_load_s;
  logic [15:0]         count_r;
  logic [2:0]          drain_r;
  logic [PIPE_W-1:0]   vpipe_r;
  logic                stim_valid_r, busy_r, done_r, pass_r;
  logic                accept_s, cap_s;

  function automatic logic [WIDTH-1:0] step_f(input logic [WIDTH-1:0] x);
    step_f = x[0] ? ((x >> 1) ^ LFSR_POLY) : (x >> 1);
  endfunction

`ifdef BIST_SEED_LOAD_EN
  assign seed_load_s = (bus.seed_i == {WIDTH{1'b0}}) ? SEED : bus.seed_i;
`else
  assign seed_load_s = SEED;
`endif

  // busy_r lags the state by one edge, so the last DONE-bound cycle still rejects start
  assign accept_s = bus.ena && bus.start_i && !busy_r &&
                    ((state_r == S_IDLE) || (state_r == S_DONE));
  assign cap_s    = (LATENCY == 0) ? stim_valid_r : vpipe_r[PIPE_W-1];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else if (bus.ena) begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) state_next_s = S_RUN;
        else          state_next_s = S_IDLE;
      end
      S_RUN: begin
        if (count_r == LAST_PAT) state_next_s = (LATENCY > 0) ? S_DRAIN : S_DONE;
        else                     state_next_s = S_RUN;
      end
      S_DRAIN: begin
        if (drain_r == LAST_DRAIN) state_next_s = S_DONE;
        else                       state_next_s = S_DRAIN;
      end
      S_DONE: begin
        if (accept_s) state_next_s = S_RUN;
        else          state_next_s = S_DONE;
      end
      default: state_next_s = S_IDLE;
    endcase
  end

  // MISR next value; pass is judged on this so the final capture is included
  always_comb begin
    misr_next_s = misr_r;
    if (cap_s) misr_next_s = step_f(misr_r) ^ bus.resp_i;
    else       misr_next_s = misr_r;
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_r       <= SEED;
      misr_r       <= {WIDTH{1'b0}};
      stim_r       <= {WIDTH{1'b0}};
      count_r      <= 16'd0;
      drain_r      <= 3'd0;
      vpipe_r      <= {PIPE_W{1'b0}};
      stim_valid_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      pass_r       <= 1'b0;
    end else if (bus.ena) begin
      vpipe_r <= PIPE_W'({vpipe_r, stim_valid_r});
      busy_r  <= (state_r == S_RUN) || (state_r == S_DRAIN);
      drain_r <= (state_r == S_DRAIN) ? drain_r + 3'd1 : 3'd0;
      if (accept_s) begin
        lfsr_r       <= seed_load_s;
        misr_r       <= {WIDTH{1'b0}};
        count_r      <= 16'd0;
        stim_valid_r <= 1'b0;
        done_r       <= 1'b0;
        pass_r       <= 1'b0;
      end else begin
        misr_r <= misr_next_s;
        done_r <= (state_r == S_DONE);
        pass_r <= (state_r == S_DONE) && (misr_next_s == GOLDEN);
        if (state_r == S_RUN) begin
          stim_r       <= lfsr_r;
          stim_valid_r <= 1'b1;
          lfsr_r       <= step_f(lfsr_r);
          count_r      <= count_r + 16'd1;
        end else begin
          stim_valid_r <= 1'b0;
        end
      end
    end
  end

  assign bus.stim_o       = stim_r;
  assign bus.stim_valid_o = stim_valid_r;
  assign bus.busy_o       = busy_r;
  assign bus.done_o       = done_r;
  assign bus.pass_o       = pass_r;
  assign bus.signature_o  = misr_r;

endmodule

// File: tb/tb_tt_bist_harness.sv
// Bench for tt_bist_harness: two instances (LATENCY 0 and 2), directed and random runs
// against a list-based model of pattern sequence and signature fold.
module tb_tt_bist_harness;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       start0 = 1'b0, start2 = 1'b0;
  logic [7:0] seed_v = 8'h00;
  logic [7:0] rnd_v = 8'h00;
  int         mode_v = 0;
  logic [7:0] d1 = 8'h00, d2 = 8'h00;
  int         n_vec = 0, n_err = 0;

  tt_bist_harness_if #(.WIDTH(8)) if0 ();
  tt_bist_harness_if #(.WIDTH(8)) if2 ();

  assign if0.ena     = ena;
  assign if2.ena     = ena;
  assign if0.start_i = start0;
  assign if2.start_i = start2;
  assign if0.resp_i  = (mode_v == 0) ? ~if0.stim_o : (mode_v == 1) ? if0.stim_o : rnd_v;
  assign if2.resp_i  = (mode_v == 0) ? ~d2 : (mode_v == 1) ? d2 : rnd_v;
`ifdef BIST_SEED_LOAD_EN
  assign if0.seed_i  = seed_v;
  assign if2.seed_i  = seed_v;
`endif

  tt_bist_harness #(.WIDTH(8), .NUM_PATTERNS(N), .LATENCY(0), .LFSR_POLY(8'hB8),
                    .SEED(8'h01), .GOLDEN(8'h36))
    u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.master));
  tt_bist_harness #(.WIDTH(8), .NUM_PATTERNS(N), .LATENCY(2), .LFSR_POLY(8'hB8),
                    .SEED(8'h01), .GOLDEN(8'h36))
    u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.master));

  always #5 clk = ~clk;

  // two-cycle delayed copy of the L=2 stimulus, frozen with ena like the DUT
  always @(posedge clk) begin
    if (ena) begin
      d1 <= if2.stim_o;
      d2 <= d1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mstep(input logic [7:0] x);
    return x[0] ? ((x >> 1) ^ 8'hB8) : (x >> 1);
  endfunction

  function automatic logic [13:0] outs_of(input int lat);
    if (lat == 0)
      return {if0.stim_o, if0.stim_valid_o, if0.busy_o, if0.done_o, if0.pass_o, 2'b00} |
             {6'd0, if0.signature_o};
    else
      return {if2.stim_o, if2.stim_valid_o, if2.busy_o, if2.done_o, if2.pass_o, 2'b00} |
             {6'd0, if2.signature_o};
  endfunction

  // One run on the chosen instance; stall_len cycles of ena=0 starting at interval stall_at
  task automatic run(input int lat, input int mode, input int stall_at, input int stall_len,
                     input bit extra_start, input logic [7:0] seed);
    logic [7:0] pat[$];
    logic [7:0] rsp[$];
    logic [7:0] got[$];
    logic [7:0] x, sig, so, sg;
    logic       sv, bz, dn, ps;
    int         k, done_t, busy_cnt;
    bit         seen;
    mode_v = mode;
    seed_v = seed;
`ifdef BIST_SEED_LOAD_EN
    x = (seed == 8'h00) ? 8'h01 : seed;
`else
    x = 8'h01;
`endif
    for (int i = 0; i < N; i++) begin
      pat.push_back(x);
      x = mstep(x);
    end
    if (lat == 0) start0 = 1'b1; else start2 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; start2 = 1'b0;
    dn = (lat == 0) ? if0.done_o : if2.done_o;
    chk("done_drop", {31'd0, dn}, 32'd0);
    seen = 1'b0; busy_cnt = 0; done_t = -1;
    for (int t = 0; t < 40 && !seen; t++) begin
      ena = !(stall_len > 0 && t >= stall_at && t < stall_at + stall_len);
      k = (stall_len > 0 && t >= stall_at + stall_len) ? t - stall_len : t;
      rnd_v = 8'($urandom);
      if (extra_start && t == 2) begin
        if (lat == 0) start0 = 1'b1; else start2 = 1'b1;
      end else begin
        start0 = 1'b0; start2 = 1'b0;
      end
      so = (lat == 0) ? if0.stim_o : if2.stim_o;
      sv = (lat == 0) ? if0.stim_valid_o : if2.stim_valid_o;
      bz = (lat == 0) ? if0.busy_o : if2.busy_o;
      dn = (lat == 0) ? if0.done_o : if2.done_o;
      if (ena && k >= 1 && k <= N + 1) chk("stim_valid", {31'd0, sv}, {31'd0, (k <= N)});
      if (ena && k >= 1 && k <= N) got.push_back(so);
      if (ena && mode == 2 && k >= 1 + lat && k <= N + lat) rsp.push_back(rnd_v);
      if (bz) busy_cnt++;
      if (dn) begin
        seen = 1'b1;
        done_t = t;
      end else begin
        @(posedge clk); #1;
      end
    end
    ena = 1'b1; start0 = 1'b0; start2 = 1'b0;
    if (mode != 2) begin
      foreach (pat[i]) rsp.push_back((mode == 0) ? ~pat[i] : pat[i]);
    end
    sig = 8'h00;
    foreach (rsp[i]) sig = mstep(sig) ^ rsp[i];
    sg = (lat == 0) ? if0.signature_o : if2.signature_o;
    ps = (lat == 0) ? if0.pass_o : if2.pass_o;
    chk("done_edge", done_t, N + lat + 1 + stall_len);
    chk("stim_count", got.size(), N);
    for (int i = 0; i < N && i < got.size(); i++) chk("stim_seq", {24'd0, got[i]}, {24'd0, pat[i]});
    chk("rsp_count", rsp.size(), N);
    chk("signature", {24'd0, sg}, {24'd0, sig});
    chk("pass", {31'd0, ps}, {31'd0, (sig == 8'h36)});
    chk("busy_cycles", busy_cnt, N + lat + stall_len);
  endtask

  initial begin
    #12;
    chk("reset_outs0", {18'd0, outs_of(0)}, 32'd0);
    chk("reset_outs2", {18'd0, outs_of(2)}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset0", {18'd0, outs_of(0)}, 32'd0);
    // start while disabled is not seen
    ena = 1'b0; start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; ena = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("ena_low_start", {18'd0, outs_of(0)}, 32'd0);

    run(0, 0, 0, 0, 1'b0, 8'h00);   // complement: 01,B8,5C,2E -> 36, pass
    run(0, 1, 0, 0, 1'b0, 8'h00);   // loopback -> 00, fail
    run(2, 0, 0, 0, 1'b0, 8'h00);   // latency 2, delayed complement -> 36
    run(0, 0, 2, 3, 1'b0, 8'h00);   // ena stall mid-RUN
    run(0, 0, 0, 0, 1'b1, 8'h00);   // start while busy ignored
    run(2, 0, 3, 2, 1'b1, 8'h00);

    // abort mid-run
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("abort_running", {31'd0, if0.stim_valid_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_outs", {18'd0, outs_of(0)}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run(0, 0, 0, 0, 1'b0, 8'h00);

    for (int r = 0; r < 10; r++) begin
      int lat, sa, sl;
      lat = (r % 2 == 0) ? 0 : 2;
      sa  = $urandom_range(1, N + lat);
      sl  = $urandom_range(0, 3);
      run(lat, 2, sa, sl, r[2], 8'($urandom));
    end

`ifdef BIST_SEED_LOAD_EN
    run(0, 0, 0, 0, 1'b0, 8'hB8);   // B8,5C,2E,17
    run(2, 1, 0, 0, 1'b0, 8'h00);   // zero seed falls back to 01
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
